// File: rtl/mcu51_pkg.sv
// mcu51_pkg: shared definitions for the MCU51 timing/fetch logic.
//   - machine-cycle frame size (STATES x PHASES clocks)
//   - state counter encodings S1..S6
//   - fetch FSM enum
//   - slot positions as {state, phase}: capture clocks and ALE clocks
//   - eff_cycles(): machine cycles an instruction really occupies
package mcu51_pkg;

  localparam int STATES = 6;
  localparam int PHASES = 2;

  localparam logic [2:0] ST_S1 = 3'd0;
  localparam logic [2:0] ST_S2 = 3'd1;
  localparam logic [2:0] ST_S3 = 3'd2;
  localparam logic [2:0] ST_S4 = 3'd3;
  localparam logic [2:0] ST_S5 = 3'd4;
  localparam logic [2:0] ST_S6 = 3'd5;

  typedef enum logic [1:0] {
    OPC = 2'd0,
    B2  = 2'd1,
    B3  = 2'd2,
    EXE = 2'd3
  } fsm_e;

  // {state, phase}; phase 1 = P2
  localparam logic [3:0] POS_S3P2 = {ST_S3, 1'b1};
  localparam logic [3:0] POS_S6P2 = {ST_S6, 1'b1};
  localparam logic [3:0] POS_S1P2 = {ST_S1, 1'b1};
  localparam logic [3:0] POS_S4P2 = {ST_S4, 1'b1};

  // Two code bytes fit in one machine cycle, so a 3-byte opcode needs two
  // cycles even when its execution would only need one.
  function automatic logic [2:0] eff_cycles(input logic [1:0] len, input logic [2:0] cyc);
    logic [2:0] fetch_cyc;
    fetch_cyc = (len == 2'd3) ? 3'd2 : 3'd1;
    return (cyc > fetch_cyc) ? cyc : fetch_cyc;
  endfunction

endpackage

// File: rtl/op_len_decode.sv
// op_len_decode: combinational 8051 opcode table.
// Ports:
//   ir  - opcode byte
//   len - instruction length in bytes (1..3)
//   cyc - machine cycles (1, 2 or 4)
// Reserved A5 falls through to the 1-byte / 1-cycle default (NOP).
module op_len_decode (
  input  logic [7:0] ir,
  output logic [1:0] len,
  output logic [2:0] cyc
);

  always_comb begin
    len = 2'd1;
    cyc = 3'd1;
    casez (ir)
      // 2 bytes, 2 cycles: AJMP/ACALL, relative jumps, bit/C ops, PUSH/POP,
      // MOV dir,@Ri/Rn, MOV @Ri/Rn,dir, DJNZ Rn
      8'h?1, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80, 8'h72, 8'h82, 8'h92,
      8'hA0, 8'hB0, 8'h86, 8'h87, 8'b1000_1???, 8'hA6, 8'hA7,
      8'b1010_1???, 8'hC0, 8'hD0, 8'b1101_1???: begin
        len = 2'd2;
        cyc = 3'd2;
      end
      // 3 bytes, 2 cycles
      8'h02, 8'h12, 8'h10, 8'h20, 8'h30, 8'h43, 8'h53, 8'h63, 8'h75,
      8'h85, 8'h90, 8'hB4, 8'hB5, 8'b1011_011?, 8'b1011_1???, 8'hD5: begin
        len = 2'd3;
        cyc = 3'd2;
      end
      // 1 byte, 2 cycles: RET/RETI, JMP @A+DPTR, MOVC, INC DPTR, MOVX
      8'h22, 8'h32, 8'h73, 8'h83, 8'h93, 8'hA3, 8'hE0, 8'hE2, 8'hE3,
      8'hF0, 8'hF2, 8'hF3: begin
        len = 2'd1;
        cyc = 3'd2;
      end
      // DIV AB, MUL AB
      8'h84, 8'hA4: begin
        len = 2'd1;
        cyc = 3'd4;
      end
      // 2 bytes, 1 cycle
      8'h05, 8'h15, 8'h24, 8'h25, 8'h34, 8'h35, 8'h42, 8'h44, 8'h45,
      8'h52, 8'h54, 8'h55, 8'h62, 8'h64, 8'h65, 8'h74, 8'h76, 8'h77,
      8'b0111_1???, 8'h94, 8'h95, 8'hA2, 8'hB2, 8'hC2, 8'hC5, 8'hD2,
      8'hE5, 8'hF5: begin
        len = 2'd2;
        cyc = 3'd1;
      end
      default: begin
        len = 2'd1;
        cyc = 3'd1;
      end
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: 8051 machine-cycle timing and code fetch sequencer.
// Ports:
//   clk, reset (sync, active high, dominates hold), hold (freeze + quiet)
//   ea       - 1 internal ROM, 0 external ROM (only affects psen)
//   ir       - opcode from the IR register, valid the clk after ir_en
//   jump_req - PC load request, honoured only on the exec_last clock
//   state/phase - S1..S6 (0..5) / P1,P2 (0,1)
//   ale, psen (active low), code_cs - external bus strobes
//   ir_en, op1_en, op2_en, pc_en, exec_last - one-clk pulses
//   mcycle   - machine cycle index within the instruction
//
// FSM:
//   state | meaning
//   OPC   | opcode fetch in slot A of mcycle 0
//   B2    | slot B of mcycle 0, byte 2 if len >= 2
//   B3    | slot A of mcycle 1, byte 3
//   EXE   | no fetch, wait for S6P2 of the last machine cycle
module fetch_sequencer
  import mcu51_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ea,
  input  logic       hold,
  input  logic [7:0] ir,
  input  logic       jump_req,
  output logic [2:0] state,
  output logic       phase,
  output logic       ale,
  output logic       psen,
  output logic       code_cs,
  output logic       ir_en,
  output logic       op1_en,
  output logic       op2_en,
  output logic       pc_en,
  output logic       exec_last,
  output logic [1:0] mcycle
);

  fsm_e       fsm, fsm_nx;
  logic [2:0] state_nx;
  logic       phase_nx;
  logic [1:0] mcycle_nx;
  logic [1:0] len;
  logic [2:0] cyc;
  logic [2:0] ncyc;
  logic [1:0] last_mc;
  logic [3:0] pos;
  logic       cap_a, cap_b, win_a, win_b, slot_act;

  op_len_decode u_dec (
    .ir  (ir),
    .len (len),
    .cyc (cyc)
  );

  assign ncyc    = eff_cycles(len, cyc);
  // ncyc of 4 wraps to index 3 here, which is what we want
  assign last_mc = ncyc[1:0] - 2'd1;
  assign pos     = {state, phase};
  assign cap_a   = (pos == POS_S3P2);
  assign cap_b   = (pos == POS_S6P2);
  assign win_a   = (state == ST_S2) || (state == ST_S3);
  assign win_b   = (state == ST_S5) || (state == ST_S6);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_S1;
      phase  <= 1'b0;
      mcycle <= 2'd0;
      fsm    <= OPC;
    end else if (!hold) begin
      state  <= state_nx;
      phase  <= phase_nx;
      mcycle <= mcycle_nx;
      fsm    <= fsm_nx;
    end
  end

  always_comb begin
    phase_nx  = (phase == 1'(PHASES - 1)) ? 1'b0 : 1'b1;
    state_nx  = state;
    if (phase == 1'(PHASES - 1))
      state_nx = (state == 3'(STATES - 1)) ? ST_S1 : state + 3'd1;
    mcycle_nx = cap_b ? mcycle + 2'd1 : mcycle;
    fsm_nx    = fsm;
    slot_act  = 1'b0;
    ir_en     = 1'b0;
    op1_en    = 1'b0;
    op2_en    = 1'b0;
    exec_last = 1'b0;
    pc_en     = 1'b0;
    ale       = 1'b0;
    psen      = 1'b1;
    code_cs   = 1'b0;

    if (!reset && !hold) begin
      ale = (pos == POS_S1P2) || (pos == POS_S4P2);

      case (fsm)
        OPC: begin
          slot_act = win_a;
          if (cap_a) begin
            ir_en  = 1'b1;
            fsm_nx = B2;
          end
        end
        B2: begin
          slot_act = win_b && (len >= 2'd2);
          if (cap_b) begin
            op1_en = (len >= 2'd2);
            // single-cycle instructions end on this same S6P2
            if (ncyc == 3'd1) begin
              exec_last = 1'b1;
              fsm_nx    = OPC;
            end else if (len == 2'd3) begin
              fsm_nx = B3;
            end else begin
              fsm_nx = EXE;
            end
          end
        end
        B3: begin
          slot_act = win_a;
          if (cap_a) begin
            op2_en = 1'b1;
            fsm_nx = EXE;
          end
        end
        EXE: begin
          if (cap_b && (mcycle == last_mc)) begin
            exec_last = 1'b1;
            fsm_nx    = OPC;
          end
        end
        default: fsm_nx = OPC;
      endcase

      if (exec_last)
        mcycle_nx = 2'd0;
      code_cs = slot_act;
      psen    = slot_act ? ea : 1'b1;
      pc_en   = ir_en || op1_en || op2_en || (exec_last && jump_req);
    end
  end

endmodule
